// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared constants and helpers for the MIPS pipeline stages.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int          XLEN               = 32;
    localparam int          WORD_BYTES         = 4;
    localparam logic [31:0] INSTR_NOP          = 32'h0000_0000;
    localparam int unsigned IMEM_WORDS_DEFAULT = 1024;

    // One bit wider than XLEN so a 4 GB memory (2^30 words) stays representable
    function automatic logic [XLEN:0] imem_bytes(input int unsigned words);
        return (XLEN+1)'(words) * (XLEN+1)'(WORD_BYTES);
    endfunction

    localparam logic [XLEN:0] IMEM_BYTES = imem_bytes(IMEM_WORDS_DEFAULT);

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module : if_id_reg
// Brief  : Pipeline register with hold (stall) and flush (bubble) controls.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_reg
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_hold,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc_plus4,
    input  logic            i_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_valid
);

    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc_plus4;
    logic            r_valid;

    // Hold outranks flush: a held stage must not lose its contents
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= INSTR_NOP;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (!i_hold) begin
            r_pc_plus4 <= i_pc_plus4;
            if (i_flush) begin
                r_instr <= INSTR_NOP;
                r_valid <= 1'b0;
            end else begin
                r_instr <= i_instr;
                r_valid <= i_valid;
            end
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module : instruction_fetch_unit
// Brief  : IF stage - owns the PC, fetches from IMEM, fills the IF/ID register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam logic [XLEN:0]   c_IMEM_BYTES = imem_bytes(IMEM_WORDS);
    localparam logic [XLEN-1:0] c_RESET_PC   = {RESET_PC[XLEN-1:2], 2'b00};

    logic [XLEN-1:0] r_pc;
    logic            r_fault;
    logic [XLEN-1:0] r_count;

    logic            w_in_range;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_next;
    logic            w_flush;
    logic            w_unused_target_lsbs;

    assign w_in_range           = ({1'b0, r_pc} < c_IMEM_BYTES);
    assign w_pc_plus4           = r_pc + XLEN'(WORD_BYTES);
    assign w_pc_next            = branch_taken ? {branch_target[XLEN-1:2], 2'b00} : w_pc_plus4;
    assign w_flush              = branch_taken | ~w_in_range;
    assign w_unused_target_lsbs = ^branch_target[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= c_RESET_PC;
            r_fault <= 1'b0;
            r_count <= '0;
        end else if (!stall) begin
            r_pc <= w_pc_next;
            if (!w_in_range) begin
                r_fault <= 1'b1;
            end
            // Only real, on-path fetches are counted
            if (w_in_range && !branch_taken) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (reset),
        .i_hold     (stall),
        .i_flush    (w_flush),
        .i_instr    (imem_data),
        .i_pc_plus4 (w_pc_plus4),
        .i_valid    (1'b1),
        .o_instr    (if_id_instr),
        .o_pc_plus4 (if_id_pc_plus4),
        .o_valid    (if_id_valid)
    );

    assign imem_addr   = r_pc;
    assign fetch_fault = r_fault;
    assign fetch_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module : tb_instruction_fetch_unit
// Brief  : Directed + random bench for instruction_fetch_unit with a PC model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: default parameters
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_addr, imem_data, if_id_instr, if_id_pc_plus4, fetch_count;
    logic        if_id_valid, fetch_fault;

    logic [31:0] mem [0:1023];
    assign imem_data = mem[imem_addr[11:2]];

    instruction_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    // Wrap instance: PC starts at the top of a 4 GB address space
    logic        reset_w = 1'b1;
    logic [31:0] imem_addr_w, imem_data_w, instr_w, pp4_w, count_w;
    logic        valid_w, fault_w;
    assign imem_data_w = imem_addr_w ^ 32'h5A5A_5A5A;

    instruction_fetch_unit #(
        .RESET_PC   (32'hFFFF_FFFC),
        .IMEM_WORDS (32'd1 << 30)
    ) dut_w (
        .clk            (clk),
        .reset          (reset_w),
        .stall          (1'b0),
        .branch_taken   (1'b0),
        .branch_target  (32'h0),
        .imem_addr      (imem_addr_w),
        .imem_data      (imem_data_w),
        .if_id_instr    (instr_w),
        .if_id_pc_plus4 (pp4_w),
        .if_id_valid    (valid_w),
        .fetch_fault    (fault_w),
        .fetch_count    (count_w)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pp4, m_count;
    logic        m_valid, m_fault;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_step();
        bit in_range;
        if (reset) begin
            m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_fault = 0; m_count = 0;
        end else if (!stall) begin
            in_range = ({32'h0, m_pc} < 64'd4096);
            if (!in_range) m_fault = 1'b1;
            m_pp4 = m_pc + 32'd4;
            if (branch_taken || !in_range) begin
                m_instr = 32'h0; m_valid = 1'b0;
            end else begin
                m_instr = mem[m_pc / 4]; m_valid = 1'b1; m_count = m_count + 1;
            end
            m_pc = branch_taken ? (branch_target & 32'hFFFF_FFFC) : m_pc + 32'd4;
        end
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".addr"},  imem_addr,      m_pc);
        check({tag, ".instr"}, if_id_instr,    m_instr);
        check({tag, ".pp4"},   if_id_pc_plus4, m_pp4);
        check({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, m_valid});
        check({tag, ".fault"}, {31'h0, fetch_fault}, {31'h0, m_fault});
        check({tag, ".count"}, fetch_count,    m_count);
    endtask

    // Advance one clock with the current inputs, then compare after the edge
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h8E12_0000;
        mem[1] = 32'h0252_9820;

        tick("reset");
        check("reset.instr_nop", if_id_instr, 32'h0);

        reset = 1'b0;
        tick("c1");
        check("c1.instr_lit", if_id_instr, 32'h8E12_0000);
        check("c1.pp4_lit",   if_id_pc_plus4, 32'd4);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick("stall");
        check("stall.addr_lit", imem_addr, 32'd4);
        stall = 1'b0;
        tick("c2");
        check("c2.instr_lit", if_id_instr, 32'h0252_9820);
        check("c2.count_lit", fetch_count, 32'd2);

        branch_taken = 1'b1; branch_target = 32'h0000_001E;
        tick("br");
        check("br.addr_lit", imem_addr, 32'h1C);
        branch_taken = 1'b0;
        tick("br_next");
        check("br_next.instr_lit", if_id_instr, mem[7]);
        check("br_next.pp4_lit",   if_id_pc_plus4, 32'h20);

        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0040;
        tick("stall_br");
        stall = 1'b0;
        tick("br_after_stall");
        check("br_after_stall.addr_lit", imem_addr, 32'h40);
        branch_taken = 1'b0;
        tick("seq");

        branch_taken = 1'b1; branch_target = 32'h0000_1000;
        tick("br_oor");
        branch_taken = 1'b0;
        tick("oor");
        check("oor.addr_lit",  imem_addr, 32'h1004);
        check("oor.fault_lit", {31'h0, fetch_fault}, 32'd1);
        tick("oor2");

        reset = 1'b1;
        tick("midreset");
        check("midreset.fault_lit", {31'h0, fetch_fault}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 300; i++) begin
            stall        = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            branch_target = $urandom_range(0, 4300);
            if (i == 250) reset = 1'b1;
            tick("rand");
            reset = 1'b0;
        end
        stall = 1'b0; branch_taken = 1'b0;

        @(posedge clk); #1;
        check("wrap.reset_addr", imem_addr_w, 32'hFFFF_FFFC);
        reset_w = 1'b0;
        @(posedge clk); #1;
        check("wrap.addr",  imem_addr_w, 32'h0);
        check("wrap.pp4",   pp4_w, 32'h0);
        check("wrap.instr", instr_w, 32'hFFFF_FFFC ^ 32'h5A5A_5A5A);
        check("wrap.valid", {31'h0, valid_w}, 32'd1);
        check("wrap.fault", {31'h0, fault_w}, 32'd0);
        check("wrap.count", count_w, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
